hilo_ctrl: RTL

Sequencer and result holder that sits directly downstream of the multi-cycle mult/div unit in the multicycle MIPS datapath. It accepts a mult/div request from the main control unit and launches the arithmetic unit with registered operands. It waits for completion with a timeout, then commits the 64-bit result into the architectural HI/LO registers. It also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo, stalling the control unit while an operation is in flight.

---
 rtl/hilo_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer for the multicycle MIPS mult/div unit: launches operations,
// waits for completion with a timeout, commits results and services mthi/mtlo.
module hilo_ctrl #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        md_start,
  output logic        md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_done,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        md_err,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_md_start;
  logic             r_md_op;
  logic [31:0]      r_md_a;
  logic [31:0]      r_md_b;
  logic             r_done;
  logic             r_div_zero;
  logic             r_md_err;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic w_div_zero;
  logic w_timeout;

  assign w_div_zero = op && (rt_val == 32'd0);
  // The abort fires on the edge where the counter would reach TIMEOUT.
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_md_start <= 1'b0;
      r_md_op    <= 1'b0;
      r_md_a     <= 32'd0;
      r_md_b     <= 32'd0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_md_err   <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else begin
      r_md_start <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_md_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            if (w_div_zero) begin
              r_div_zero <= 1'b1;
            end else begin
              r_md_op    <= op;
              r_md_a     <= rs_val;
              r_md_b     <= rt_val;
              r_md_start <= 1'b1;
              r_state    <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion wins over a timeout landing in the same cycle.
          if (md_done) begin
            r_hi    <= md_hi;
            r_lo    <= md_lo;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            r_md_err <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign md_start = r_md_start;
  assign md_op    = r_md_op;
  assign md_a     = r_md_a;
  assign md_b     = r_md_b;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign md_err   = r_md_err;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
